// File: rtl/sdp_core_cmux.sv
// sdp_core_cmux: per-layer source mux between the CACC stream (flying mode)
// and the M-RDMA stream (memory mode), feeding the SDP datapath through a
// 2-entry skid buffer so that both source readys come straight from flops.
//
// Handshake rule for every port pair: a beat transfers on a rising clock edge
// where valid & ready are both 1; the sender holds pd stable while valid & ~ready.
module sdp_core_cmux #(
    parameter int DATA_W = 256,
    parameter int PD_W   = DATA_W + 2
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              reg2dp_op_en,
    input  logic              reg2dp_flying_mode,
    input  logic              cacc2sdp_valid,
    output logic              cacc2sdp_ready,
    input  logic [PD_W-1:0]   cacc2sdp_pd,
    input  logic              sdp_mrdma2cmux_valid,
    output logic              sdp_mrdma2cmux_ready,
    input  logic [PD_W-1:0]   sdp_mrdma2cmux_pd,
    output logic              sdp_cmux2dp_valid,
    input  logic              sdp_cmux2dp_ready,
    output logic [PD_W-1:0]   sdp_cmux2dp_pd,
    output logic              cmux2reg_done,
    output logic [31:0]       dp2reg_cmux_beat_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              op_en_d;
    logic              src_sel;
    logic              src_sel_nxt;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [PD_W-1:0]   in_pd;
    logic              push;
    logic              pop;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [PD_W-1:0]   mem [2];
    logic              ready_nxt;
    logic              done_nxt;

    // Layer start on the op_en rising edge; abort whenever op_en drops mid-layer.
    assign start = reg2dp_op_en & ~op_en_d;
    assign abort = (state != IDLE) & ~reg2dp_op_en;

    // Source select is frozen for the whole layer.
    assign src_sel_nxt = ((state == IDLE) && start) ? reg2dp_flying_mode : src_sel;
    assign in_valid    = src_sel ? cacc2sdp_valid : sdp_mrdma2cmux_valid;
    assign in_pd       = src_sel ? cacc2sdp_pd    : sdp_mrdma2cmux_pd;

    // The ready flops are only ever high for the selected source.
    assign push = in_valid & (src_sel ? cacc2sdp_ready : sdp_mrdma2cmux_ready);
    assign pop  = sdp_cmux2dp_valid & sdp_cmux2dp_ready;

    assign sdp_cmux2dp_valid = (cnt != 2'd0);
    assign sdp_cmux2dp_pd    = mem[rd_ptr];

    // Next-state, next-occupancy, next-ready and done decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 2'(push) - 2'(pop);
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (push && in_pd[DATA_W+1]) state_nxt = DRAIN;
                DRAIN: begin
                    if (cnt_nxt == 2'd0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        ready_nxt = (state_nxt == RUN) && (cnt_nxt < 2'd2);
    end

    // Control registers: FSM, op_en delay, source select, readys, done pulse.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state                <= IDLE;
            op_en_d              <= 1'b0;
            src_sel              <= 1'b0;
            cacc2sdp_ready       <= 1'b0;
            sdp_mrdma2cmux_ready <= 1'b0;
            cmux2reg_done        <= 1'b0;
        end else begin
            state                <= state_nxt;
            op_en_d              <= reg2dp_op_en;
            src_sel              <= src_sel_nxt;
            cacc2sdp_ready       <= ready_nxt & src_sel_nxt;
            sdp_mrdma2cmux_ready <= ready_nxt & ~src_sel_nxt;
            cmux2reg_done        <= done_nxt;
        end
    end

    // Skid buffer pointers and occupancy; abort flushes everything.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (abort) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Skid storage; packets pass through untouched.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push && !abort) begin
            mem[wr_ptr] <= in_pd;
        end
    end

    // Beat counter: cleared at layer start, saturating count of output beats.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            dp2reg_cmux_beat_cnt <= 32'd0;
        end else if ((state == IDLE) && start) begin
            dp2reg_cmux_beat_cnt <= 32'd0;
        end else if (pop && (dp2reg_cmux_beat_cnt != 32'hFFFF_FFFF)) begin
            dp2reg_cmux_beat_cnt <= dp2reg_cmux_beat_cnt + 32'd1;
        end
    end

endmodule

// File: doc/sdp_core_cmux.md
Name: sdp_core_cmux

Overview:
- Input mux stage directly downstream of the SDP M-RDMA. Selects per layer between the CACC stream (flying mode) and the M-RDMA stream (memory mode), and forwards the selected beats to the SDP datapath.
- Buffers beats in a 2-entry skid so all ready outputs are registered.
- Tracks layer boundaries, counts forwarded beats, and pulses a done flag once the layer's last beat has left the block.

Parameters:
- DATA_W, 256, datapath payload width in bits.
- PD_W, DATA_W+2, packet width. Layout: [DATA_W-1:0] data, [DATA_W] batch_end, [DATA_W+1] layer_end.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- reg2dp_op_en  in  1  layer enable, level.
- reg2dp_flying_mode  in  1  source select: 1 = CACC, 0 = M-RDMA.
- cacc2sdp_valid  in  1  CACC beat valid.
- cacc2sdp_ready  out  1  CACC beat ready.
- cacc2sdp_pd  in  PD_W  CACC packet.
- sdp_mrdma2cmux_valid  in  1  M-RDMA beat valid.
- sdp_mrdma2cmux_ready  out  1  M-RDMA beat ready.
- sdp_mrdma2cmux_pd  in  PD_W  M-RDMA packet.
- sdp_cmux2dp_valid  out  1  datapath beat valid.
- sdp_cmux2dp_ready  in  1  datapath ready.
- sdp_cmux2dp_pd  out  PD_W  datapath packet.
- cmux2reg_done  out  1  one-cycle layer-done pulse.
- dp2reg_cmux_beat_cnt  out  32  beats forwarded in the current/last layer.

Behaviour:
- Clock and reset: nvdla_core_clk; nvdla_core_rstn is asynchronous, active-low.
- Reset values: state = IDLE, skid empty, all valid/ready = 0, cmux2reg_done = 0, beat_cnt = 0, pd = 0, op_en_d = 0, src_sel = 0.
- Start: op_en_d registers reg2dp_op_en. start = reg2dp_op_en & ~op_en_d.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. Latch src_sel = reg2dp_flying_mode and clear beat_cnt in the same cycle.
  - RUN -> DRAIN when a beat with layer_end = 1 is accepted (input handshake). No further input is accepted in DRAIN.
  - DRAIN -> IDLE when the skid is empty. cmux2reg_done = 1 for exactly the following cycle (registered).
- Abort: reg2dp_op_en = 0 while in RUN or DRAIN:
  - Next cycle: state = IDLE, skid flushed (valid = 0).
  - No done pulse is generated.
  - beat_cnt holds its value.
- reg2dp_flying_mode changes after start are ignored until the next start.
- Ready rules (registered):
  - selected_ready = (state == RUN) & (skid count next < 2).
  - Non-selected source ready = 0 at all times; its beats stall.
  - Both readys = 0 in IDLE and DRAIN.
- Skid:
  - 2-entry FIFO, registered read pointer, output pd driven from the head entry.
  - Valid/ready handshakes are AXI-style: transfer when valid & ready. Upstream must hold pd while valid & ~ready.
  - Latency: beat accepted at cycle N appears on sdp_cmux2dp_valid at N+1.
  - Throughput: 1 beat/cycle while downstream is ready.
  - count 1 with push and pop in the same cycle -> count stays 1, order preserved.
  - Full (count 2) -> ready low the next cycle. Downstream stall never drops or duplicates a beat.
- pd is passed through unmodified; batch_end is not interpreted.
- beat_cnt increments on every output handshake and saturates at 0xFFFFFFFF.
- Start and abort in the same cycle is impossible by construction: start needs op_en = 1, abort needs op_en = 0.
- A layer_end beat arriving when count = 1 is accepted normally. DRAIN waits for both entries to pop.

Test Plan:
- Memory mode: flying_mode = 0, op_en rise, M-RDMA sends 4 beats (last with layer_end), downstream always ready -> out data matches in order, first out 1 cycle after first accept, cacc2sdp_ready stays 0, done pulses once 1 cycle after 4th pop, beat_cnt = 4.
- Flying mode: flying_mode = 1, CACC sends 3 beats while M-RDMA valid held high -> only CACC beats forwarded, sdp_mrdma2cmux_ready = 0 throughout, beat_cnt = 3.
- Backpressure: downstream ready low for 5 cycles mid-stream -> source ready drops after 2 buffered beats, no loss or duplication, order intact, done only after last pop.
- Mode change: toggle flying_mode mid-layer -> source unchanged. Next op_en rise uses the new mode and beat_cnt clears to 0.
- Abort: drop op_en with 2 beats buffered in RUN -> next cycle valid = 0 and ready = 0, no done pulse, restart forwards fresh data only.
- Reset: assert rstn low during DRAIN -> all outputs 0 immediately (asynchronous). After release the block stays in IDLE until a new op_en rise.
